// File: rtl/control_unit_pipe_pkg.sv
// rtl/control_unit_pipe_pkg.sv - opcodes, command codes, condition codes, types and helpers for the ID/EX control decoder
package control_unit_pipe_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  typedef enum logic {ST_IDLE, ST_MUL_BUSY} state_t;

  // Control word as held in the ID/EX register; exe_cmd is widened at the port
  typedef struct packed {
    logic       valid;
    logic       s;
    logic       b;
    logic [3:0] exe_cmd;
    logic       mem_w_en;
    logic       mem_r_en;
    logic       wb_en;
  } ctrl_t;

  // ARM condition field evaluated against {N,Z,C,V}; 1111 never passes
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = ~z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = ~c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = ~n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = ~v;
      COND_HI: cond_pass = c & ~z;
      COND_LS: cond_pass = ~c | z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = ~z & (n == v);
      COND_LE: cond_pass = z | (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // Opcode to ALU command; compares and tests reuse SUB and AND
  function automatic logic [3:0] alu_cmd(input logic [3:0] op);
    case (op)
      OP_MOV:  alu_cmd = CMD_MOV;
      OP_MVN:  alu_cmd = CMD_MVN;
      OP_ADD:  alu_cmd = CMD_ADD;
      OP_ADC:  alu_cmd = CMD_ADC;
      OP_SUB:  alu_cmd = CMD_SUB;
      OP_SBC:  alu_cmd = CMD_SBC;
      OP_AND:  alu_cmd = CMD_AND;
      OP_ORR:  alu_cmd = CMD_ORR;
      OP_EOR:  alu_cmd = CMD_EOR;
      OP_CMP:  alu_cmd = CMD_SUB;
      OP_TST:  alu_cmd = CMD_AND;
      default: alu_cmd = CMD_MOV;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_pipe_if.sv
// rtl/control_unit_pipe_if.sv - decode-side fields in, ID/EX controls out
interface control_unit_pipe_if #(
  parameter int EXE_CMD_W = 4
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           op_code;
  logic [1:0]           mode;
  logic                 s_in;
  logic [3:0]           cond;
  logic [3:0]           status_nzcv;
  logic                 mul_in;
  logic                 out_valid;
  logic [EXE_CMD_W-1:0] exe_cmd;
  logic                 mem_r_en;
  logic                 mem_w_en;
  logic                 wb_en;
  logic                 b;
  logic                 s;
  logic                 busy;
  logic [EXE_CMD_W+4:0] ctrl_bus;

  modport master (
    output in_valid, op_code, mode, s_in, cond, status_nzcv, mul_in,
    input  in_ready, out_valid, exe_cmd, mem_r_en, mem_w_en, wb_en, b, s, busy, ctrl_bus
  );

  modport slave (
    input  in_valid, op_code, mode, s_in, cond, status_nzcv, mul_in,
    output in_ready, out_valid, exe_cmd, mem_r_en, mem_w_en, wb_en, b, s, busy, ctrl_bus
  );
endinterface

// File: rtl/control_unit_pipe_cond_check.sv
// rtl/control_unit_pipe_cond_check.sv - combinational ARM condition evaluator
module control_unit_pipe_cond_check
  import control_unit_pipe_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);
  assign pass = cond_pass(cond, nzcv);
endmodule

// File: rtl/control_unit_pipe.sv
// rtl/control_unit_pipe.sv - registered ID-stage control decoder with stall/flush and MUL sequencer
module control_unit_pipe
  import control_unit_pipe_pkg::*;
#(
  parameter int EXE_CMD_W   = 4,
  parameter int MUL_CYCLES  = 3,
  parameter int SUPPORT_MUL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall,
  input  logic flush,
  control_unit_pipe_if.slave bus
);
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_q, ctrl_d, pend_q, pend_d, dec;
  logic             pass, is_mul, accept;

  control_unit_pipe_cond_check u_cond (
    .cond (bus.cond),
    .nzcv (bus.status_nzcv),
    .pass (pass)
  );

  assign bus.busy     = (state_q == ST_MUL_BUSY);
  assign bus.in_ready = ~stall & ~bus.busy & rst_n;
  assign accept       = bus.in_valid & bus.in_ready & ~flush;
  assign is_mul       = (SUPPORT_MUL != 0) && bus.mul_in && (bus.mode == MODE_DP);

  // Decode presented fields into a control word; a failed condition becomes a bubble
  always_comb begin
    dec         = '0;
    dec.valid   = 1'b1;
    dec.exe_cmd = CMD_MOV;
    if (pass) begin
      case (bus.mode)
        MODE_DP: begin
          dec.s = bus.s_in;
          if (is_mul) begin
            dec.exe_cmd = CMD_MUL;
            dec.wb_en   = 1'b1;
          end else begin
            dec.exe_cmd = alu_cmd(bus.op_code);
            dec.wb_en   = (bus.op_code != OP_CMP) && (bus.op_code != OP_TST);
          end
        end
        MODE_MEM: begin
          dec.exe_cmd  = CMD_ADD;
          dec.wb_en    = bus.s_in;
          dec.mem_r_en = bus.s_in;
          dec.mem_w_en = ~bus.s_in;
        end
        MODE_BR: begin
          dec.exe_cmd = alu_cmd(bus.op_code);
          dec.b       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next state of the ID/EX register and sequencer: flush beats stall beats accept/count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    pend_d  = pend_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ctrl_d  = '0;
    end else if (stall) begin
      // everything holds
    end else if (state_q == ST_MUL_BUSY) begin
      cnt_d  = cnt_q - CNT_ONE;
      ctrl_d = '0;
      if (cnt_q == CNT_ONE) begin
        ctrl_d  = pend_q;
        state_d = ST_IDLE;
      end
    end else if (accept) begin
      if (is_mul && pass && (MUL_CYCLES > 1)) begin
        state_d = ST_MUL_BUSY;
        cnt_d   = CNT_LOAD;
        pend_d  = dec;
        ctrl_d  = '0;
      end else begin
        ctrl_d = dec;
      end
    end else begin
      ctrl_d = '0;
    end
  end

  // State, counter, pending MUL word and ID/EX register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.out_valid = ctrl_q.valid;
  assign bus.exe_cmd   = EXE_CMD_W'(ctrl_q.exe_cmd);
  assign bus.mem_r_en  = ctrl_q.mem_r_en;
  assign bus.mem_w_en  = ctrl_q.mem_w_en;
  assign bus.wb_en     = ctrl_q.wb_en;
  assign bus.b         = ctrl_q.b;
  assign bus.s         = ctrl_q.s;
  assign bus.ctrl_bus  = {ctrl_q.s, ctrl_q.b, bus.exe_cmd, ctrl_q.mem_w_en, ctrl_q.mem_r_en, ctrl_q.wb_en};

endmodule

// File: tb/tb_control_unit_pipe.sv
// tb/tb_control_unit_pipe.sv - randomized self-checking bench for control_unit_pipe
module tb_control_unit_pipe;
  localparam int EXE_CMD_W  = 4;
  localparam int MUL_CYCLES = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic stall;
  logic flush;

  int checks   = 0;
  int failures = 0;

  logic [3:0] cmd_tab [16];
  logic       m_valid;
  logic [8:0] m_bus;
  logic [8:0] m_pend;
  int         m_left;

  control_unit_pipe_if #(.EXE_CMD_W(EXE_CMD_W)) bus ();

  control_unit_pipe #(
    .EXE_CMD_W   (EXE_CMD_W),
    .MUL_CYCLES  (MUL_CYCLES),
    .SUPPORT_MUL (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Odd condition codes negate the even code below them; 1110/1111 fall out as always/never
  function automatic logic cond_ok(input logic [3:0] cd, input logic [3:0] nz);
    logic n, z, c, v, base;
    {n, z, c, v} = nz;
    case (cd[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ cd[0];
  endfunction

  // Expected {s,b,exe_cmd,mem_w_en,mem_r_en,wb_en} for an accepted instruction
  function automatic logic [8:0] exp_ctrl(input logic [3:0] op, input logic [1:0] md, input logic si,
                                          input logic [3:0] cd, input logic [3:0] nz, input logic mu);
    logic [8:0] r;
    if (!cond_ok(cd, nz)) r = {2'b00, 4'b0001, 3'b000};
    else begin
      case (md)
        2'b00:   r = mu ? {si, 1'b0, 4'b1010, 3'b001}
                        : {si, 1'b0, cmd_tab[op], 2'b00, !(op == 4'b1010 || op == 4'b1000)};
        2'b01:   r = {2'b00, 4'b0010, ~si, si, si};
        2'b10:   r = {2'b01, cmd_tab[op], 3'b000};
        default: r = {2'b00, 4'b0001, 3'b000};
      endcase
    end
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_bus   = '0;
    m_pend  = '0;
    m_left  = 0;
  endtask

  // Drive one cycle of inputs, advance the model across the next edge, compare after it
  task automatic step(input logic v, input logic [3:0] op, input logic [1:0] md, input logic si,
                      input logic [3:0] cd, input logic [3:0] nz, input logic mu,
                      input logic st, input logic fl);
    logic [8:0] e;
    bus.in_valid    = v;
    bus.op_code     = op;
    bus.mode        = md;
    bus.s_in        = si;
    bus.cond        = cd;
    bus.status_nzcv = nz;
    bus.mul_in      = mu;
    stall           = st;
    flush           = fl;
    #1;
    check("in_ready", 32'(bus.in_ready), 32'(!st && m_left == 0));
    e = exp_ctrl(op, md, si, cd, nz, mu);
    if (fl) begin
      m_valid = 1'b0; m_bus = '0; m_left = 0;
    end else if (st) begin
      m_left = m_left;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_valid = 1'b1; m_bus = m_pend; end
      else begin m_valid = 1'b0; m_bus = '0; end
    end else if (v) begin
      if (mu && md == 2'b00 && cond_ok(cd, nz) && MUL_CYCLES > 1) begin
        m_left = MUL_CYCLES - 1; m_pend = e; m_valid = 1'b0; m_bus = '0;
      end else begin
        m_valid = 1'b1; m_bus = e;
      end
    end else begin
      m_valid = 1'b0; m_bus = '0;
    end
    @(negedge clk);
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("ctrl_bus", 32'(bus.ctrl_bus), 32'(m_bus));
    check("exe_cmd", 32'(bus.exe_cmd), 32'(m_bus[6:3]));
    check("wb_en", 32'(bus.wb_en), 32'(m_bus[0]));
    check("busy", 32'(bus.busy), 32'(m_left > 0));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) cmd_tab[i] = 4'b0001;
    cmd_tab[4'b1101] = 4'b0001; cmd_tab[4'b1111] = 4'b1001; cmd_tab[4'b0100] = 4'b0010;
    cmd_tab[4'b0101] = 4'b0011; cmd_tab[4'b0010] = 4'b0100; cmd_tab[4'b0110] = 4'b0101;
    cmd_tab[4'b0000] = 4'b0110; cmd_tab[4'b1100] = 4'b0111; cmd_tab[4'b0001] = 4'b1000;
    cmd_tab[4'b1010] = 4'b0100; cmd_tab[4'b1000] = 4'b0110;
    model_reset();

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.op_code = '0; bus.mode = '0; bus.s_in = 1'b0;
    bus.cond = '0; bus.status_nzcv = '0; bus.mul_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_ctrl_bus", 32'(bus.ctrl_bus), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // ADD, S=1, AL
    step(1'b1, 4'b0100, 2'b00, 1'b1, 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("add_bus", 32'(bus.ctrl_bus), 32'(9'b1_0_0010_001));
    // SUB EQ with Z clear then set
    step(1'b1, 4'b0010, 2'b00, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("sub_eq_fail", 32'(bus.ctrl_bus), 32'(9'b0_0_0001_000));
    step(1'b1, 4'b0010, 2'b00, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0);
    check("sub_eq_pass", 32'(bus.ctrl_bus), 32'(9'b0_0_0100_001));
    // LDR then STR
    step(1'b1, 4'b0100, 2'b01, 1'b1, 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("ldr_bus", 32'(bus.ctrl_bus), 32'(9'b0_0_0010_011));
    step(1'b1, 4'b0100, 2'b01, 1'b0, 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("str_bus", 32'(bus.ctrl_bus), 32'(9'b0_0_0010_100));

    // MUL, no stall: result after the third edge
    step(1'b1, 4'b0000, 2'b00, 1'b0, 4'b1110, 4'b0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 2'b00, 1'b0, 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("mul_mid_busy", 32'(bus.busy), 32'd1);
    step(1'b0, 4'b0000, 2'b00, 1'b0, 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("mul_done_cmd", 32'(bus.exe_cmd), 32'(4'b1010));
    check("mul_done_valid", 32'(bus.out_valid), 32'd1);

    // MUL with two stall cycles in the middle: result after the fifth edge
    step(1'b1, 4'b0011, 2'b00, 1'b1, 4'b1110, 4'b0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 2'b00, 1'b0, 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 2'b00, 1'b0, 4'b1110, 4'b0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 2'b00, 1'b0, 4'b1110, 4'b0000, 1'b0, 1'b1, 1'b0);
    check("mul_stall_4th", 32'(bus.out_valid), 32'd0);
    step(1'b0, 4'b0000, 2'b00, 1'b0, 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("mul_stall_5th", 32'(bus.ctrl_bus), 32'(9'b1_0_1010_001));

    // Flush during MUL_BUSY, then flush+stall over a live register
    step(1'b1, 4'b0000, 2'b00, 1'b0, 4'b1110, 4'b0000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b0100, 2'b00, 1'b0, 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b1);
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_ready", 32'(bus.in_ready), 32'd1);
    step(1'b1, 4'b0100, 2'b00, 1'b0, 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b0100, 2'b00, 1'b0, 4'b1110, 4'b0000, 1'b0, 1'b1, 1'b1);
    check("flush_stall_valid", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a MUL
    step(1'b1, 4'b0000, 2'b00, 1'b0, 4'b1110, 4'b0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 2'b00, 1'b0, 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_ctrl_bus", 32'(bus.ctrl_bus), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_rel_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_rel_busy", 32'(bus.busy), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 9) < 8, 4'($urandom), 2'($urandom), 1'($urandom),
           ($urandom_range(0, 1) == 0) ? 4'b1110 : 4'($urandom), 4'($urandom),
           $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
